kp_midi_ctrl: RTL and testbench

MIDI note/controller front end for the Karplus-Strong voice: parses a byte stream from the UART receiver and drives the voice's trigger, velocity, tuning, decay and filter inputs. It sits between the MIDI byte source and the voice on the 96 kHz audio clock domain. It converts each note-on into a debounce-safe active-low trigger pulse, with velocity and delay length already valid and stable.

---
 rtl/kp_midi_pkg.sv | 39 +++
 rtl/kp_note_rom.sv | 55 +++++
 rtl/kp_midi_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_kp_midi_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kp_midi_pkg.sv
// Shared types and constants for the MIDI front end of the Karplus-Strong voice.
package kp_midi_pkg;

   // Byte-stream parser position within a channel message
   typedef enum logic [1:0] {
      P_IDLE,
      P_DATA1,
      P_DATA2
   } parser_state_t;

   // Trigger pulse generator: low pulse, then holdoff before the next pulse
   typedef enum logic [1:0] {
      T_IDLE,
      T_LOW,
      T_HOLD
   } trig_state_t;

   // Status nibbles of the channel messages we act on
   localparam logic [3:0] NOTE_OFF = 4'h8;
   localparam logic [3:0] NOTE_ON  = 4'h9;
   localparam logic [3:0] CC       = 4'hB;

   // Controller numbers
   localparam logic [6:0] CC_DECAY = 7'd72;
   localparam logic [6:0] CC_FILT  = 7'd74;

   // Lowest note of the tuning table; lower notes are folded up by octaves
   localparam logic [6:0] NOTE_MIN = 7'd43;

   // Power-up voice settings: A4 string length and a long sustain
   localparam logic [9:0]  DEFAULT_DELAY = 10'd218;
   localparam logic [11:0] DEFAULT_DECAY = 12'h7F0;

   // Message types that carry two data bytes and therefore use the full parser path
   function automatic logic is_two_byte(input logic [3:0] status_hi);
      return (status_hi == NOTE_OFF) || (status_hi == NOTE_ON) || (status_hi == CC);
   endfunction

endpackage

// File: rtl/kp_note_rom.sv
// Combinational note number to string length (samples) lookup.
// Notes below the table are raised by whole octaves; above it the base length
// is halved once per octave.
module kp_note_rom
   import kp_midi_pkg::*;
(
   input  logic [6:0] note,
   output logic [9:0] delay_length
);

   logic [6:0] folded;
   logic [6:0] k;
   logic [3:0] idx;
   logic [2:0] oct;
   logic [9:0] rom_val;

   // Fold low notes upward; four octave steps take note 0 past NOTE_MIN
   always_comb begin
      folded = note;
      for (int i = 0; i < 4; i++) begin
         if (folded < NOTE_MIN) begin
            folded = folded + 7'd12;
         end
      end
   end

   // Split the offset above NOTE_MIN into semitone and octave
   always_comb begin
      k   = folded - NOTE_MIN;
      idx = 4'(k % 7'd12);
      oct = 3'(k / 7'd12);
   end

   // Base lengths for the lowest octave, one entry per semitone
   always_comb begin
      case (idx)
         4'd0:    rom_val = 10'd980;
         4'd1:    rom_val = 10'd925;
         4'd2:    rom_val = 10'd873;
         4'd3:    rom_val = 10'd824;
         4'd4:    rom_val = 10'd778;
         4'd5:    rom_val = 10'd734;
         4'd6:    rom_val = 10'd693;
         4'd7:    rom_val = 10'd654;
         4'd8:    rom_val = 10'd617;
         4'd9:    rom_val = 10'd582;
         4'd10:   rom_val = 10'd550;
         4'd11:   rom_val = 10'd519;
         default: rom_val = 10'd0;
      endcase
   end

   assign delay_length = rom_val >> oct;

endmodule

// File: rtl/kp_midi_ctrl.sv
// MIDI byte-stream parser and note trigger generator for the Karplus-Strong voice.
// A note-on becomes a fixed-width active-low trig pulse; velocity and
// delay_length only change on the cycle trig falls so the voice sees stable values.
module kp_midi_ctrl
   import kp_midi_pkg::*;
#(
   parameter int CHANNEL      = 0,
   parameter int TRIG_LOW_CYC = 8,
   parameter int HOLDOFF_CYC  = 8
) (
   input  logic        a_clk,
   input  logic        reset_n,
   input  logic [7:0]  midi_byte,
   input  logic        midi_valid,
   output logic        trig,
   output logic [6:0]  velocity,
   output logic [9:0]  delay_length,
   output logic [11:0] decay,
   output logic [2:0]  filtsw,
   output logic        gate
);

   localparam logic [3:0] CH = 4'(CHANNEL);
   localparam int CNT_MAX = (TRIG_LOW_CYC > HOLDOFF_CYC) ? TRIG_LOW_CYC : HOLDOFF_CYC;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] LOW_LOAD  = CNT_W'(TRIG_LOW_CYC - 1);
   localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLDOFF_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   // Parser state
   parser_state_t p_state_reg, p_state_next;
   logic [7:0]    rs_reg, rs_next;
   logic          rs_valid_reg, rs_valid_next;
   logic [6:0]    data1_reg, data1_next;
   logic          dispatch;

   // Latched note and settings
   logic [6:0]    note_reg;
   logic [6:0]    note_vel_reg;
   logic          gate_reg;
   logic          req_reg;
   logic [11:0]   decay_reg;
   logic [2:0]    filtsw_reg;

   // Trigger generator state
   trig_state_t      t_state_reg, t_state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic             pending_reg, pending_next;
   logic             fire;
   logic [6:0]       velocity_reg;
   logic [9:0]       delay_reg;
   logic [9:0]       rom_delay;

   // Message decode at the data2 byte
   logic [6:0] data2;
   logic       msg_ours;
   logic       note_on;
   logic       note_off;
   logic       cc_decay;
   logic       cc_filt;

   assign data2    = midi_byte[6:0];
   assign msg_ours = dispatch && (rs_reg[3:0] == CH);
   assign note_on  = msg_ours && (rs_reg[7:4] == NOTE_ON) && (data2 != 7'd0);
   assign note_off = msg_ours && ((rs_reg[7:4] == NOTE_OFF) ||
                                  ((rs_reg[7:4] == NOTE_ON) && (data2 == 7'd0)));
   assign cc_decay = msg_ours && (rs_reg[7:4] == CC) && (data1_reg == CC_DECAY);
   assign cc_filt  = msg_ours && (rs_reg[7:4] == CC) && (data1_reg == CC_FILT);

   // Parser next state: one byte per cycle, realtime bytes are transparent
   always_comb begin
      p_state_next  = p_state_reg;
      rs_next       = rs_reg;
      rs_valid_next = rs_valid_reg;
      data1_next    = data1_reg;
      dispatch      = 1'b0;
      if (midi_valid && (midi_byte < 8'hF8)) begin
         if (midi_byte >= 8'hF0) begin
            rs_valid_next = 1'b0;
            p_state_next  = P_IDLE;
         end else if (midi_byte[7]) begin
            rs_next       = midi_byte;
            rs_valid_next = 1'b1;
            p_state_next  = is_two_byte(midi_byte[7:4]) ? P_DATA1 : P_IDLE;
         end else begin
            case (p_state_reg)
               P_IDLE: begin
                  // Running status: a bare data byte starts a new message
                  if (rs_valid_reg && is_two_byte(rs_reg[7:4])) begin
                     data1_next   = data2;
                     p_state_next = P_DATA2;
                  end
               end
               P_DATA1: begin
                  data1_next   = data2;
                  p_state_next = P_DATA2;
               end
               P_DATA2: begin
                  dispatch     = 1'b1;
                  p_state_next = P_IDLE;
               end
               default: p_state_next = P_IDLE;
            endcase
         end
      end
   end

   // Parser registers
   always_ff @(posedge a_clk) begin
      if (!reset_n) begin
         p_state_reg  <= P_IDLE;
         rs_reg       <= 8'd0;
         rs_valid_reg <= 1'b0;
         data1_reg    <= 7'd0;
      end else begin
         p_state_reg  <= p_state_next;
         rs_reg       <= rs_next;
         rs_valid_reg <= rs_valid_next;
         data1_reg    <= data1_next;
      end
   end

   // Act on dispatched messages: note latch, gate, controllers, trigger request
   always_ff @(posedge a_clk) begin
      if (!reset_n) begin
         note_reg     <= 7'd0;
         note_vel_reg <= 7'd0;
         gate_reg     <= 1'b0;
         req_reg      <= 1'b0;
         decay_reg    <= DEFAULT_DECAY;
         filtsw_reg   <= 3'd0;
      end else begin
         req_reg <= note_on;
         if (note_on) begin
            note_reg     <= data1_reg;
            note_vel_reg <= data2;
            gate_reg     <= 1'b1;
         end else if (note_off && (data1_reg == note_reg)) begin
            gate_reg <= 1'b0;
         end
         if (cc_decay) begin
            decay_reg <= {1'b0, data2, 4'b0000};
         end
         if (cc_filt) begin
            filtsw_reg <= data2[6:4];
         end
      end
   end

   kp_note_rom u_rom (
      .note         (note_reg),
      .delay_length (rom_delay)
   );

   // Trigger next state: fixed low time, then holdoff; a note-on arriving while
   // busy is remembered and fires straight out of the holdoff
   always_comb begin
      t_state_next = t_state_reg;
      cnt_next     = cnt_reg;
      pending_next = pending_reg;
      fire         = 1'b0;
      case (t_state_reg)
         T_IDLE: begin
            if (req_reg) begin
               fire         = 1'b1;
               t_state_next = T_LOW;
               cnt_next     = LOW_LOAD;
            end
         end
         T_LOW: begin
            if (req_reg) begin
               pending_next = 1'b1;
            end
            if (cnt_reg == '0) begin
               t_state_next = T_HOLD;
               cnt_next     = HOLD_LOAD;
            end else begin
               cnt_next = cnt_reg - CNT_ONE;
            end
         end
         T_HOLD: begin
            if (cnt_reg == '0) begin
               if (pending_reg || req_reg) begin
                  fire         = 1'b1;
                  t_state_next = T_LOW;
                  cnt_next     = LOW_LOAD;
                  pending_next = 1'b0;
               end else begin
                  t_state_next = T_IDLE;
               end
            end else begin
               cnt_next = cnt_reg - CNT_ONE;
               if (req_reg) begin
                  pending_next = 1'b1;
               end
            end
         end
         default: t_state_next = T_IDLE;
      endcase
   end

   // Trigger registers; voice parameters are loaded only when a pulse starts
   always_ff @(posedge a_clk) begin
      if (!reset_n) begin
         t_state_reg  <= T_IDLE;
         cnt_reg      <= '0;
         pending_reg  <= 1'b0;
         velocity_reg <= 7'd0;
         delay_reg    <= DEFAULT_DELAY;
      end else begin
         t_state_reg <= t_state_next;
         cnt_reg     <= cnt_next;
         pending_reg <= pending_next;
         if (fire) begin
            velocity_reg <= note_vel_reg;
            delay_reg    <= rom_delay;
         end
      end
   end

   assign trig         = (t_state_reg != T_LOW);
   assign velocity     = velocity_reg;
   assign delay_length = delay_reg;
   assign decay        = decay_reg;
   assign filtsw       = filtsw_reg;
   assign gate         = gate_reg;

endmodule

// File: tb/tb_kp_midi_ctrl.sv
// Bench for kp_midi_ctrl: a message-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized byte streams.
module tb_kp_midi_ctrl;

   localparam int CHANNEL = 0;
   localparam int LOW     = 8;
   localparam int HOLD    = 8;

   logic        a_clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [7:0]  midi_byte = 8'd0;
   logic        midi_valid = 1'b0;
   logic        trig;
   logic [6:0]  velocity;
   logic [9:0]  delay_length;
   logic [11:0] decay;
   logic [2:0]  filtsw;
   logic        gate;

   kp_midi_ctrl #(
      .CHANNEL      (CHANNEL),
      .TRIG_LOW_CYC (LOW),
      .HOLDOFF_CYC  (HOLD)
   ) dut (
      .a_clk        (a_clk),
      .reset_n      (reset_n),
      .midi_byte    (midi_byte),
      .midi_valid   (midi_valid),
      .trig         (trig),
      .velocity     (velocity),
      .delay_length (delay_length),
      .decay        (decay),
      .filtsw       (filtsw),
      .gate         (gate)
   );

   always #5 a_clk = ~a_clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   // Tuning rule from note number, straight arithmetic
   int rom_tab [12] = '{980, 925, 873, 824, 778, 734, 693, 654, 617, 582, 550, 519};
   function automatic int tune(input int n);
      int f;
      f = n;
      while (f < 43) f += 12;
      return rom_tab[(f - 43) % 12] >> ((f - 43) / 12);
   endfunction

   // ---------------- reference model, stepped at every rising edge ----------
   int         edge_no = 0;
   bit         have_fire = 0;
   int         last_fire = 0;
   bit         pend = 0;
   int         pend_note = 0, pend_vel = 0;
   bit         req_prev = 0;
   logic [7:0] m_rs = 0;
   bit         m_rs_ok = 0;
   int         dq[$];
   int         m_note = 0, m_vel = 0;
   bit         m_gate = 0;
   int         m_decay = 'h7F0, m_filt = 0;
   int         exp_vel = 0, exp_dly = 218;

   initial begin : model
      logic       s_rn, s_v;
      logic [7:0] s_b;
      bit         exp_trig;
      forever begin
         @(posedge a_clk);
         s_rn = reset_n;
         s_v  = midi_valid;
         s_b  = midi_byte;
         if (!s_rn) begin
            have_fire = 0; pend = 0; req_prev = 0;
            m_rs_ok = 0; dq.delete();
            m_note = 0; m_vel = 0; m_gate = 0; m_decay = 'h7F0; m_filt = 0;
            exp_vel = 0; exp_dly = 218;
         end else begin
            // a note-on dispatched last edge becomes a trigger request now
            if (req_prev) begin
               pend = 1; pend_note = m_note; pend_vel = m_vel;
            end
            if (pend && (!have_fire || (edge_no - last_fire) >= LOW + HOLD)) begin
               exp_vel = pend_vel;
               exp_dly = tune(pend_note);
               last_fire = edge_no;
               have_fire = 1;
               pend = 0;
            end
            req_prev = 0;
            if (s_v) begin
               if (s_b >= 8'hF8) begin
                  // realtime: no effect
               end else if (s_b >= 8'hF0) begin
                  m_rs_ok = 0; dq.delete();
               end else if (s_b[7]) begin
                  m_rs = s_b; m_rs_ok = 1; dq.delete();
               end else if (m_rs_ok && (m_rs[7:4] == 4'h8 || m_rs[7:4] == 4'h9 || m_rs[7:4] == 4'hB)) begin
                  dq.push_back(int'(s_b[6:0]));
                  if (dq.size() == 2) begin
                     if (int'(m_rs[3:0]) == CHANNEL) begin
                        if (m_rs[7:4] == 4'h9 && dq[1] != 0) begin
                           m_note = dq[0]; m_vel = dq[1]; m_gate = 1; req_prev = 1;
                        end else if (m_rs[7:4] == 4'h8 || m_rs[7:4] == 4'h9) begin
                           if (dq[0] == m_note) m_gate = 0;
                        end else if (dq[0] == 72) begin
                           m_decay = dq[1] * 16;
                        end else if (dq[0] == 74) begin
                           m_filt = dq[1] / 16;
                        end
                     end
                     dq.delete();
                  end
               end
            end
         end
         exp_trig = !(have_fire && (edge_no - last_fire) < LOW);
         #1;
         chk("trig", trig, exp_trig);
         chk("velocity", velocity, exp_vel);
         chk("delay_length", delay_length, exp_dly);
         chk("decay", decay, m_decay);
         chk("filtsw", filtsw, m_filt);
         chk("gate", gate, m_gate);
         edge_no++;
      end
   end

   // ---------------- driver with negedge sampling of outputs ----------------
   int   cur_cyc = 0;
   bit   prev_trig = 1;
   int   fall_cyc[$], fall_vel[$], fall_dly[$], rise_cyc[$];
   logic last_gate;
   logic [6:0]  last_vel;
   logic [9:0]  last_dly;
   logic [11:0] last_decay;
   logic [2:0]  last_filt;

   task automatic cyc(input logic v, input logic [7:0] b, input logic rn);
      @(negedge a_clk);
      cur_cyc++;
      if (prev_trig && trig === 1'b0) begin
         fall_cyc.push_back(cur_cyc);
         fall_vel.push_back(int'(velocity));
         fall_dly.push_back(int'(delay_length));
      end
      if (!prev_trig && trig === 1'b1) rise_cyc.push_back(cur_cyc);
      prev_trig  = (trig !== 1'b0);
      last_gate  = gate;
      last_vel   = velocity;
      last_dly   = delay_length;
      last_decay = decay;
      last_filt  = filtsw;
      midi_valid = v;
      midi_byte  = b;
      reset_n    = rn;
   endtask

   task automatic send(input logic [7:0] b);
      cyc(1'b1, b, 1'b1);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 8'($urandom), 1'b1);
   endtask

   task automatic rst_cycles(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 8'd0, 1'b0);
   endtask

   task automatic clear_q();
      fall_cyc.delete(); fall_vel.delete(); fall_dly.delete(); rise_cyc.delete();
   endtask

   task automatic rand_msg();
      int k;
      k = $urandom_range(0, 15);
      case (k)
         0, 1, 2, 3, 4, 5: begin
            send(8'h90); send(8'($urandom_range(0, 127)));
            send(($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 127)));
         end
         6, 7: begin
            send(8'($urandom_range(0, 127))); send(8'($urandom_range(0, 127)));
         end
         8: begin
            send(8'h80); send(8'($urandom_range(0, 127))); send(8'($urandom_range(0, 127)));
         end
         9: begin
            send(8'hB0);
            send(8'(72 + 2 * $urandom_range(0, 1) + (($urandom_range(0, 3) == 0) ? 1 : 0)));
            send(8'($urandom_range(0, 127)));
         end
         10: begin
            send(8'h90 | 8'($urandom_range(1, 15))); send(8'($urandom_range(0, 127)));
            send(8'($urandom_range(1, 127)));
         end
         11: send(8'($urandom_range(248, 255)));
         12: send(8'($urandom_range(240, 247)));
         13: begin
            send(8'($urandom_range(12, 14)) << 4); send(8'($urandom_range(0, 127)));
         end
         14: send(8'($urandom_range(0, 127)));
         default: idle($urandom_range(1, 30));
      endcase
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin : stim
      int a;
      rst_cycles(3);
      idle(1);
      chk("rst_trig", last_gate === 1'b0 && trig === 1'b1 ? 1 : 0, 1);
      chk("rst_vel", last_vel, 0);
      chk("rst_dly", last_dly, 218);
      chk("rst_decay", last_decay, 12'h7F0);
      chk("rst_filt", last_filt, 0);

      // Tuning model pinned to hand-computed values
      chk("tune69", tune(69), 218);
      chk("tune48", tune(48), 734);
      chk("tune43", tune(43), 980);
      chk("tune127", tune(127), 7);
      chk("tune0", tune(0), 734);

      // Basic note-on
      clear_q();
      send(8'h90); send(8'h45); send(8'h64);
      a = cur_cyc;
      idle(20);
      chk("t1_nfall", fall_cyc.size(), 1);
      if (fall_cyc.size() > 0) begin
         chk("t1_fall_at", fall_cyc[0] - a, 2);
         chk("t1_vel", fall_vel[0], 100);
         chk("t1_dly", fall_dly[0], 218);
      end
      if (rise_cyc.size() > 0) chk("t1_low_len", rise_cyc[0] - a, 10);
      else chk("t1_nrise", rise_cyc.size(), 1);
      chk("t1_gate", last_gate, 1);

      // Note-off by zero velocity, then a mismatched note-off
      clear_q();
      send(8'h90); send(8'h45); send(8'h00);
      idle(3);
      chk("off_gate", last_gate, 0);
      chk("off_nfall", fall_cyc.size(), 0);
      send(8'h90); send(8'h45); send(8'h64);
      idle(25);
      send(8'h80); send(8'h46); send(8'h00);
      idle(3);
      chk("off_other_gate", last_gate, 1);

      // Running status: second note deferred by the pulse spacing
      clear_q();
      send(8'h90); send(8'h30); send(8'h40);
      a = cur_cyc;
      send(8'h2B); send(8'h7F);
      idle(40);
      chk("rs_nfall", fall_cyc.size(), 2);
      if (fall_cyc.size() == 2) begin
         chk("rs_fall0_at", fall_cyc[0] - a, 2);
         chk("rs_dly0", fall_dly[0], 734);
         chk("rs_vel0", fall_vel[0], 64);
         chk("rs_spacing", fall_cyc[1] - fall_cyc[0], 16);
         chk("rs_dly1", fall_dly[1], 980);
         chk("rs_vel1", fall_vel[1], 127);
      end

      // Realtime byte between data bytes; wrong-channel message ignored
      clear_q();
      send(8'h90); send(8'h45); send(8'hF8); send(8'h50);
      idle(25);
      chk("rt_nfall", fall_cyc.size(), 1);
      if (fall_cyc.size() > 0) chk("rt_vel", fall_vel[0], 80);
      clear_q();
      send(8'h91); send(8'h2B); send(8'h7F);
      idle(25);
      chk("ch1_nfall", fall_cyc.size(), 0);
      chk("ch1_dly", last_dly, 218);
      chk("ch1_vel", last_vel, 80);

      // Controllers
      send(8'hB0); send(8'h48); send(8'h10);
      idle(2);
      chk("cc_decay_lo", last_decay, 12'h100);
      send(8'hB0); send(8'h48); send(8'h7F);
      idle(2);
      chk("cc_decay_hi", last_decay, 12'h7F0);
      send(8'hB0); send(8'h4A); send(8'h50);
      idle(2);
      chk("cc_filt", last_filt, 5);

      // Two note-ons 3 cycles apart, a third during the second pulse, then reset
      idle(30);
      clear_q();
      send(8'h90); send(8'h40); send(8'h10);
      a = cur_cyc;
      send(8'h41); idle(1); send(8'h20);
      idle(a + 18 - cur_cyc);
      send(8'h30); send(8'h50);
      idle(1);
      rst_cycles(1);
      idle(50);
      chk("rst_nfall", fall_cyc.size(), 2);
      if (fall_cyc.size() == 2) begin
         chk("rst_fall0_at", fall_cyc[0] - a, 2);
         chk("rst_dly0", fall_dly[0], 291);
         chk("rst_fall1_at", fall_cyc[1] - a, 18);
         chk("rst_vel1", fall_vel[1], 32);
         chk("rst_dly1", fall_dly[1], 275);
      end
      chk("rst_nrise", rise_cyc.size(), 2);
      if (rise_cyc.size() == 2) chk("rst_rise_at", rise_cyc[1] - a, 23);
      chk("rst_vel_after", last_vel, 0);

      // Randomized streams with occasional gaps and resets
      for (int i = 0; i < 400; i++) begin
         rand_msg();
         if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 24));
         else idle($urandom_range(0, 2));
         if ($urandom_range(0, 299) == 0) rst_cycles(2);
      end
      idle(40);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
